pipe_operand_mux: RTL and testbench

- Parametrised, registered N:1 operand-select stage for the 5-stage pipeline datapath; generalises the combinational 2:1/3:1 selectors to any width and input count.
- Selected word passes through a one-cycle pipeline register with valid/ready handshake and a one-entry skid buffer, so back-pressure from the next stage never drops a word.
- Used between forwarding-source selection and the ALU operand latch; supports pipeline flush on branch/exception.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_operand_mux_skid_buffer.sv | 100 ++++++++++
 rtl/pipe_operand_mux.sv | 128 ++++++++++++
 tb/tb_pipe_operand_mux.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg (package)
//  Description : Shared definitions for the pipeline datapath stage registers.
//                - clog2_min1 : select-field width that never collapses to 0
//                - c_default_data : word produced for an out-of-range select
//                - pipe_payload_t : {data, sel} payload carried by stage regs
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default data word for out-of-range selects.
    localparam logic [31:0] c_default_data = 32'h0000_0000;

    // Select field width used by the shared payload struct.
    localparam int c_payload_sel_w = 8;

    // Payload carried by pipeline stage registers: the data word together with
    // the select index that produced it.
    typedef struct packed {
        logic [31:0]                data;
        logic [c_payload_sel_w-1:0] sel;
    } pipe_payload_t;

    // Width of an index able to address n entries, never less than 1 bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_operand_mux_skid_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : skid_buffer
//  Description : Two-entry registered valid/ready stage (main + skid entry).
//                The upstream ready comes straight from a flop, so it never
//                depends combinationally on the downstream ready.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_flush         - drop every held word (and this cycle's input)
//                i_data/i_valid  - upstream payload and valid
//                o_ready         - upstream may present a word
//                o_data/o_valid  - registered payload and valid
//                i_ready         - downstream accepts o_data
//  Revision    : 1.0 - initial release
// ============================================================================
module skid_buffer
    import pipe_pkg::*;
#(
    parameter int PAYLOAD_W = 34
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic [PAYLOAD_W-1:0] i_data,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [PAYLOAD_W-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready
);

    logic [PAYLOAD_W-1:0] r_main_data_q;
    logic [PAYLOAD_W-1:0] w_main_data_d;
    logic                 r_main_valid_q;
    logic                 w_main_valid_d;
    logic [PAYLOAD_W-1:0] r_skid_data_q;
    logic [PAYLOAD_W-1:0] w_skid_data_d;
    logic                 r_skid_valid_q;
    logic                 w_skid_valid_d;

    logic w_accept;
    logic w_main_free;

    // Upstream may send whenever the skid entry is empty; at most two words
    // are ever held (main + skid).
    assign o_ready     = !r_skid_valid_q;
    assign w_accept    = i_valid && o_ready;
    // Main register can take a new word if it is empty or emptying this cycle.
    assign w_main_free = !r_main_valid_q || i_ready;

    always_comb begin
        w_main_data_d  = r_main_data_q;
        w_main_valid_d = r_main_valid_q;
        w_skid_data_d  = r_skid_data_q;
        w_skid_valid_d = r_skid_valid_q;

        if (i_flush) begin
            // Data registers keep their contents; only the valids matter.
            w_main_valid_d = 1'b0;
            w_skid_valid_d = 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid_q) begin
                // Older word in skid moves forward first to keep FIFO order.
                w_main_data_d  = r_skid_data_q;
                w_main_valid_d = 1'b1;
                w_skid_valid_d = w_accept;
                if (w_accept) begin
                    w_skid_data_d = i_data;
                end
            end else begin
                if (w_accept) begin
                    w_main_data_d = i_data;
                end
                w_main_valid_d = w_accept;
            end
        end else if (w_accept) begin
            // Main is stalled: park the new word in skid, main holds steady.
            w_skid_data_d  = i_data;
            w_skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data_q  <= '0;
            r_main_valid_q <= 1'b0;
            r_skid_data_q  <= '0;
            r_skid_valid_q <= 1'b0;
        end else begin
            r_main_data_q  <= w_main_data_d;
            r_main_valid_q <= w_main_valid_d;
            r_skid_data_q  <= w_skid_data_d;
            r_skid_valid_q <= w_skid_valid_d;
        end
    end

    assign o_data  = r_main_data_q;
    assign o_valid = r_main_valid_q;

endmodule : skid_buffer
`default_nettype wire

// File: rtl/pipe_operand_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_operand_mux
//  Description : Registered N:1 operand select with valid/ready handshake and a
//                one-entry skid buffer; supports pipeline flush.
//  Ports       : clk, reset       - clock, synchronous active-high reset
//                in_data          - NUM_INPUTS packed words, word k at
//                                   [k*WIDTH +: WIDTH]
//                selection_line   - index of the word to forward
//                in_valid/in_ready- upstream handshake
//                flush            - discard all held words
//                out_data/out_sel - selected word and the index that chose it
//                out_valid/out_ready - downstream handshake
//                sel_err, sel_err_count - only with PIPE_OPERAND_MUX_SEL_ERR_EN:
//                                   sticky out-of-range flag and saturating
//                                   count of out-of-range accepts
//  Options     : PIPE_OPERAND_MUX_SEL_ERR_EN enables the select-error outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_operand_mux
    import pipe_pkg::*;
#(
    parameter int          WIDTH         = 32,
    parameter int          NUM_INPUTS    = 4,
    parameter logic [31:0] DEFAULT_VALUE = c_default_data,
    localparam int         SEL_W         = clog2_min1(NUM_INPUTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]            selection_line,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        flush,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_sel,
    output logic                        out_valid,
    input  logic                        out_ready
`ifdef PIPE_OPERAND_MUX_SEL_ERR_EN
    ,
    output logic                        sel_err,
    output logic [15:0]                 sel_err_count
`endif
);

    localparam int c_payload_w = WIDTH + SEL_W;

    logic [WIDTH-1:0]       w_sel_word;
    logic [c_payload_w-1:0] w_in_payload;
    logic [c_payload_w-1:0] w_out_payload;

    // Word selection; indices past the last input fall back to the default,
    // resized (truncated or zero-extended) to the data width.
    always_comb begin
        w_sel_word = WIDTH'(DEFAULT_VALUE);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (selection_line == SEL_W'(k)) begin
                w_sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_in_payload = {w_sel_word, selection_line};

    skid_buffer #(
        .PAYLOAD_W (c_payload_w)
    ) u_skid_buffer (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_data  (w_in_payload),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (w_out_payload),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign out_data = w_out_payload[c_payload_w-1:SEL_W];
    assign out_sel  = w_out_payload[SEL_W-1:0];

`ifdef PIPE_OPERAND_MUX_SEL_ERR_EN
    logic        w_sel_in_range;
    logic        w_err_accept;
    logic        r_sel_err_q;
    logic        w_sel_err_d;
    logic [15:0] r_sel_err_count_q;
    logic [15:0] w_sel_err_count_d;

    always_comb begin
        w_sel_in_range = 1'b0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (selection_line == SEL_W'(k)) begin
                w_sel_in_range = 1'b1;
            end
        end
    end

    // Counted on every accept, including one made in a flush cycle.
    assign w_err_accept = in_valid && in_ready && !w_sel_in_range;

    always_comb begin
        w_sel_err_d       = r_sel_err_q;
        w_sel_err_count_d = r_sel_err_count_q;
        if (w_err_accept) begin
            w_sel_err_d = 1'b1;
            if (r_sel_err_count_q != 16'hFFFF) begin
                w_sel_err_count_d = r_sel_err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_err_q       <= 1'b0;
            r_sel_err_count_q <= 16'd0;
        end else begin
            r_sel_err_q       <= w_sel_err_d;
            r_sel_err_count_q <= w_sel_err_count_d;
        end
    end

    assign sel_err       = r_sel_err_q;
    assign sel_err_count = r_sel_err_count_q;
`endif

endmodule : pipe_operand_mux
`default_nettype wire

// File: tb/tb_pipe_operand_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_operand_mux
//  Description : Scoreboard bench for pipe_operand_mux (WIDTH=32, 3 inputs so
//                select value 3 is out of range). Stimulus pushes expected
//                {data, sel} words; a negedge monitor compares them in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_operand_mux;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int SW = 2;

    localparam logic [N*W-1:0] c_din = {32'h33, 32'h22, 32'h11};

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N*W-1:0]  in_data = c_din;
    logic [SW-1:0]   selection_line = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            flush = 1'b0;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_sel;
    logic            out_valid;
    logic            out_ready = 1'b0;
`ifdef PIPE_OPERAND_MUX_SEL_ERR_EN
    logic            sel_err;
    logic [15:0]     sel_err_count;
`endif

    pipe_operand_mux #(
        .WIDTH         (W),
        .NUM_INPUTS    (N),
        .DEFAULT_VALUE (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_data        (in_data),
        .selection_line (selection_line),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .flush          (flush),
        .out_data       (out_data),
        .out_sel        (out_sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready)
`ifdef PIPE_OPERAND_MUX_SEL_ERR_EN
        ,
        .sel_err        (sel_err),
        .sel_err_count  (sel_err_count)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard: written only by stimulus; the monitor advances rd_idx.
    logic [W+SW-1:0] exp_q[$];
    int              rd_idx = 0;
    int              checks = 0;
    int              errors = 0;

    // Per-cycle status expectations set by stimulus, checked by the monitor.
    logic        ck_valid_en = 0, ck_valid_exp = 0;
    logic        ck_ready_en = 0, ck_ready_exp = 0;
    logic        ck_zero_en = 0, ck_empty_en = 0;
    logic        ck_err_en = 0, ck_err_exp = 0;
    logic [15:0] ck_cnt_exp = 0;

    logic         stall_prev = 0;
    logic [W-1:0] prev_data = '0;
    logic [SW-1:0] prev_sel = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic pending;
        pending = exp_q.size() > rd_idx;
        if (out_valid) begin
            chk("word_pending_on_valid", 64'(pending), 64'd1);
            if (pending) begin
                chk("out_data", 64'(out_data), 64'(exp_q[rd_idx][W+SW-1:SW]));
                chk("out_sel", 64'(out_sel), 64'(exp_q[rd_idx][SW-1:0]));
                if (out_ready) rd_idx++;
            end
        end
        if (stall_prev && out_valid) begin
            chk("stall_data_stable", 64'(out_data), 64'(prev_data));
            chk("stall_sel_stable", 64'(out_sel), 64'(prev_sel));
        end
        stall_prev = out_valid && !out_ready && !flush && !reset;
        prev_data  = out_data;
        prev_sel   = out_sel;
        chk("in_flight_le_2", 64'(exp_q.size() - rd_idx > 2), 64'd0);
        if (flush || reset) rd_idx = exp_q.size();

        if (ck_valid_en) chk("out_valid", 64'(out_valid), 64'(ck_valid_exp));
        if (ck_ready_en) chk("in_ready", 64'(in_ready), 64'(ck_ready_exp));
        if (ck_zero_en) begin
            chk("out_data_after_reset", 64'(out_data), 64'd0);
            chk("out_sel_after_reset", 64'(out_sel), 64'd0);
        end
        if (ck_empty_en) chk("words_outstanding", 64'(exp_q.size() - rd_idx), 64'd0);
`ifdef PIPE_OPERAND_MUX_SEL_ERR_EN
        if (ck_err_en) begin
            chk("sel_err", 64'(sel_err), 64'(ck_err_exp));
            chk("sel_err_count", 64'(sel_err_count), 64'(ck_cnt_exp));
        end
`endif
    end

    // One cycle of stimulus; exp is the hand-computed word the DUT must emit.
    task automatic step(input logic rst, input logic v, input logic [SW-1:0] s,
                        input logic fl, input logic rd, input logic [N*W-1:0] din,
                        input logic [W-1:0] exp);
        @(posedge clk);
        #1;
        ck_valid_en = 0; ck_ready_en = 0; ck_zero_en = 0;
        ck_empty_en = 0; ck_err_en = 0;
        reset = rst; in_valid = v; selection_line = s; flush = fl;
        out_ready = rd; in_data = din;
        if (v && in_ready && !fl && !rst) exp_q.push_back({exp, s});
    endtask

    task automatic d(input logic v, input logic [SW-1:0] s, input logic fl,
                     input logic rd, input logic [W-1:0] exp);
        step(1'b0, v, s, fl, rd, c_din, exp);
    endtask

    task automatic st(input logic v, input logic r);
        ck_valid_en = 1; ck_valid_exp = v;
        ck_ready_en = 1; ck_ready_exp = r;
    endtask

    task automatic er(input logic e, input logic [15:0] c);
        ck_err_en = 1; ck_err_exp = e; ck_cnt_exp = c;
    endtask

    function automatic logic [W-1:0] model(input logic [N*W-1:0] din, input logic [SW-1:0] s);
        return (int'(s) < N) ? din[int'(s)*W +: W] : 32'h0;
    endfunction

    initial begin
        logic [N*W-1:0] rdin;
        logic [SW-1:0]  rs;
        // Reset
        step(1, 0, 0, 0, 0, c_din, 0);
        step(1, 0, 0, 0, 0, c_din, 0);
        d(0, 0, 0, 1, 0);            st(0, 1); ck_zero_en = 1; er(0, 0);
        // Pass-through
        d(1, 0, 0, 1, 32'h11);       st(0, 1);
        d(1, 1, 0, 1, 32'h22);       st(1, 1);
        d(1, 2, 0, 1, 32'h33);       st(1, 1);
        d(0, 0, 0, 1, 0);            st(1, 1);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Back-pressure
        d(1, 0, 0, 0, 32'h11);       st(0, 1);
        d(1, 1, 0, 0, 32'h22);       st(1, 1);
        d(1, 2, 0, 0, 32'h33);       st(1, 0);   // not accepted
        d(0, 0, 0, 0, 0);            st(1, 0);
        d(0, 0, 0, 1, 0);            st(1, 0);
        d(0, 0, 0, 1, 0);            st(1, 1);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Out-of-range select
        d(1, 3, 0, 1, 32'h0);        st(0, 1);
        d(0, 0, 0, 1, 0);            st(1, 1); er(1, 1);
        d(1, 3, 0, 1, 32'h0);
        d(1, 3, 0, 1, 32'h0);
        d(1, 3, 0, 1, 32'h0);
        d(0, 0, 0, 1, 0);            er(1, 4);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Flush with two words held
        d(1, 0, 0, 0, 32'h11);
        d(1, 1, 0, 0, 32'h22);
        d(1, 2, 1, 0, 32'h33);       st(1, 0);
        d(0, 0, 0, 1, 0);            st(0, 1); er(1, 4);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Flush discards a word accepted in the flush cycle
        d(1, 0, 0, 0, 32'h11);
        d(1, 2, 1, 0, 32'h33);       st(1, 1);
        d(0, 0, 0, 1, 0);            st(0, 1);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Reset mid-stall
        d(1, 0, 0, 0, 32'h11);
        d(1, 1, 0, 0, 32'h22);
        d(0, 0, 0, 0, 0);            st(1, 0);
        step(1, 0, 0, 0, 0, c_din, 0);
        d(1, 2, 0, 1, 32'h33);       st(0, 1); ck_zero_en = 1; er(0, 0);
        d(0, 0, 0, 1, 0);            st(1, 1);
        d(0, 0, 0, 1, 0);            st(0, 1);
        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rdin = {$urandom, $urandom, $urandom};
            rs   = SW'($urandom_range(0, 3));
            step(0, 1'($urandom_range(0, 1)), rs, ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), rdin, model(rdin, rs));
        end
        // Drain and confirm nothing was lost
        d(0, 0, 0, 1, 0);
        d(0, 0, 0, 1, 0);
        d(0, 0, 0, 1, 0);            st(0, 1); ck_empty_en = 1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_operand_mux
`default_nettype wire
